// File: rtl/carry_gen_stage_if.sv
// Operand/result handshake bundle for the carry-generate stage.
// The slave side is the stage itself; the master side feeds operands and consumes P/C.
interface carry_gen_stage_if #(
    parameter int unsigned BITS = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] p;
    logic [BITS-1:0] c;
    logic            cout;
    logic            last;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, c, cout, last
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, c, cout, last
    );
endinterface

// File: rtl/carry_gen_stage.sv
// Vector carry-generate stage: per element forms propagate and lookahead carries,
// optionally chaining the carry across elements, with a one-deep registered output.
module carry_gen_stage #(
    parameter int unsigned BITS = 4,
    parameter int unsigned VL_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [VL_W-1:0] vl_i,
    input  logic            sub_i,
    input  logic            chain_i,
    output logic            busy_o,
    output logic            done_o,
    carry_gen_stage_if.slave bus
);
    localparam int Bw = int'(BITS);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;

    logic [VL_W-1:0] vl_q, vl_d;
    logic [VL_W-1:0] cnt_q, cnt_d;
    logic            sub_q, sub_d;
    logic            chain_q, chain_d;
    logic            carry_q, carry_d;
    logic [BITS-1:0] p_q, p_d;
    logic [BITS-1:0] c_q, c_d;
    logic            cout_q, cout_d;
    logic            last_q, last_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;

    logic            in_ready;
    logic            accept;
    logic            out_fire;
    logic            is_last;
    logic [BITS-1:0] b_eff;
    logic [BITS-1:0] prop;
    logic [BITS-1:0] gen;
    logic [BITS:0]   carry;
    logic            cin;
    logic            acc;
    logic            term;

    assign accept   = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign is_last  = (cnt_q == vl_q - VL_W'(1));

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && (vl_i != '0)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && is_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_fire && last_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
        busy_o   = (state_q != StIdle);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.c         = c_q;
    assign bus.cout      = cout_q;
    assign bus.last      = last_q;
    assign done_o        = done_q;

    // Flat lookahead: c[i+1] = G[i] | P[i]G[i-1] | ... | P[i:0]cin, no ripple dependency.
    always_comb begin
        b_eff = sub_q ? ~bus.b : bus.b;
        cin   = chain_q ? carry_q : sub_q;
        prop  = bus.a ^ b_eff;
        gen   = bus.a & b_eff;
        carry = '0;
        acc   = 1'b0;
        term  = 1'b0;
        carry[0] = cin;
        for (int i = 0; i < Bw; i++) begin
            acc = cin;
            for (int j = 0; j <= i; j++) begin
                acc = acc & prop[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & prop[k];
                end
                acc = acc | term;
            end
            carry[i+1] = acc;
        end
    end

    // Datapath and control next state
    always_comb begin
        vl_d        = vl_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        chain_d     = chain_q;
        carry_d     = carry_q;
        p_d         = p_q;
        c_d         = c_q;
        cout_d      = cout_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        if (state_q == StIdle && start_i) begin
            if (vl_i != '0) begin
                vl_d    = vl_i;
                sub_d   = sub_i;
                chain_d = chain_i;
                cnt_d   = '0;
                carry_d = sub_i;
            end else begin
                done_d = 1'b1;
            end
        end

        if (state_q == StDrain && out_fire && last_q) begin
            done_d = 1'b1;
        end

        // Accept overrides consume so a simultaneous pair loads with no bubble.
        if (accept) begin
            p_d         = prop;
            c_d         = carry[BITS-1:0];
            cout_d      = carry[BITS];
            last_d      = is_last;
            carry_d     = carry[BITS];
            cnt_d       = cnt_q + VL_W'(1);
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vl_q        <= '0;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            chain_q     <= 1'b0;
            carry_q     <= 1'b0;
            p_q         <= '0;
            c_q         <= '0;
            cout_q      <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vl_q        <= vl_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            chain_q     <= chain_d;
            carry_q     <= carry_d;
            p_q         <= p_d;
            c_q         <= c_d;
            cout_q      <= cout_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: doc/carry_gen_stage.md
CARRY_GEN_STAGE -- requirements
Module: carry_gen_stage

Interface
REQ-001 Parameter BITS, default 4, element width in bits.
REQ-002 Parameter VL_W, default 4, width of the vector-length field.
REQ-003 clk_i  input  1  single clock; all state on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 start_i  input  1  start a vector operation; honoured only in IDLE.
REQ-006 vl_i  input  VL_W  element count, sampled with start_i.
REQ-007 sub_i  input  1  subtract mode (A - B), sampled with start_i.
REQ-008 chain_i  input  1  carry-chain mode across elements, sampled with start_i.
REQ-009 in_valid_i  input  1  operand pair valid.
REQ-010 in_ready_o  output  1  stage accepts an operand pair.
REQ-011 A_i, B_i  input  BITS each  element operands.
REQ-012 out_valid_o  output  1  P_o, C_o, cout_o and last_o are valid.
REQ-013 out_ready_i  input  1  the downstream sum stage consumes the output.
REQ-014 P_o  output  BITS  registered propagate, A ^ B'.
REQ-015 C_o  output  BITS  registered carry into each bit; the sum stage forms P_o ^ C_o.
REQ-016 cout_o  output  1  registered carry out of the MSB.
REQ-017 last_o  output  1  output belongs to the final element.
REQ-018 busy_o  output  1  high in any state other than IDLE.
REQ-019 done_o  output  1  one-cycle completion pulse.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-021 IDLE: start_i=1 with vl_i!=0 SHALL latch vl, sub and chain, clear the element counter, set carry_reg to sub_i and go to RUN.
REQ-022 IDLE: start_i=1 with vl_i=0 SHALL pulse done_o on the next cycle and stay in IDLE.
REQ-023 start_i SHALL be ignored in RUN and DRAIN; latched parameters do not change.
REQ-024 in_ready_o SHALL be RUN && (!out_valid_o || out_ready_i), and 0 in IDLE and DRAIN.
REQ-025 On accept (in_valid_i && in_ready_o), the stage SHALL form B' = sub ? ~B_i : B_i and cin = chain ? carry_reg : sub.
REQ-026 On accept, it SHALL compute P = A_i^B', G = A_i&B', c[0] = cin and c[i+1] = G[i] | (P[i] & c[i]) (carry lookahead, combinational).
REQ-027 On accept, P_o<=P, C_o<=c[BITS-1:0], cout_o<=c[BITS], last_o<=(cnt==vl-1), carry_reg<=c[BITS], cnt<=cnt+1 and out_valid_o<=1; latency is one cycle.
REQ-028 Without chain, each element SHALL use cin=sub and ignore carry_reg.
REQ-029 If out_valid_o=1 and out_ready_i=0, all outputs SHALL hold stable.
REQ-030 If out_ready_i=1 and there is no accept, out_valid_o SHALL clear next cycle.
REQ-031 A simultaneous consume and accept SHALL load the new element with no bubble.
REQ-032 When the element with cnt==vl-1 is accepted, the FSM SHALL go to DRAIN.
REQ-033 DRAIN SHALL wait for the output handshake with last_o=1, then pulse done_o for one cycle in the same cycle it returns to IDLE.
REQ-034 vl = 2^VL_W-1 SHALL complete without counter wrap; cnt is VL_W bits wide.
REQ-035 Arithmetic SHALL be modulo 2^BITS; the overflow indication is cout_o only.

Reset
REQ-036 rst_i SHALL, asynchronously, force IDLE and clear cnt, carry_reg, P_o, C_o, cout_o, last_o, out_valid_o, busy_o and done_o to 0; in_ready_o then reads 0.
REQ-037 Reset mid-RUN or mid-DRAIN SHALL discard pending output; after release, no done_o is produced for the aborted operation.

Verification
REQ-038 Assert rst_i during RUN with out_valid_o=1 -> all outputs 0 immediately (before the next clock edge), state IDLE.
REQ-039 BITS=4, vl=1, add, A=3, B=5 -> P_o=0110, C_o=1110, cout_o=0, last_o=1; P_o^C_o=1000; done_o pulses after the consume.
REQ-040 Sub, A=5, B=3 -> P_o=1001, C_o=1011, cout_o=1; P_o^C_o=0010.
REQ-041 vl=2, chain, add, {A,B} = {F,1} then {0,0} -> element 0: C_o=1110, cout_o=1, last_o=0; element 1: C_o=0001, cout_o=0, last_o=1; sums 0000, 0001.
REQ-042 Hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> outputs stable, in_ready_o=0; on release, back-to-back accepts resume with no lost or duplicated element.
REQ-043 start_i with vl_i=0 -> busy_o stays 0, one done_o pulse; start_i during RUN -> ignored.
